// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive byte FIFO between the UART receiver and the CSR port.
// Define UART_RX_FIFO_IRQ_EN to add the irq_o level interrupt.
package uart_rx_fifo_pkg;
  typedef logic [11:0] CsrAddrT;
  typedef logic [4:0]  r;
  typedef logic [31:0] word;
  typedef enum logic [2:0] {
    CSRRW  = 3'b001,
    CSRRS  = 3'b010,
    CSRRC  = 3'b011,
    CSRRWI = 3'b101,
    CSRRSI = 3'b110,
    CSRRCI = 3'b111
  } csr_op_t;
endpackage

module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int      DEPTH       = 16,
  parameter CsrAddrT DATA_ADDR   = 12'h52,
  parameter CsrAddrT STATUS_ADDR = 12'h53,
  parameter int      IRQ_LEVEL   = 1
) (
  input  logic    clk_i,
  input  logic    reset_ni,
  input  logic    rx_valid,
  input  logic [7:0] rx_data,
  input  logic    csr_enable,
  input  CsrAddrT csr_addr,
  input  r        rs1_zimm,
  input  word     rs1_data,
  input  csr_op_t csr_op,
  output word     csr_data_out
`ifdef UART_RX_FIFO_IRQ_EN
  ,
  output logic    irq_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [CW-1:0] count;
  logic [CW-1:0] count_n;
  logic          ovf;
  logic          ovf_n;

  logic data_sel;
  logic stat_sel;
  logic empty;
  logic full;
  logic pop;
  logic push;
  logic drop;
  logic clr_bit;
  logic clr;
  logic unused_ok;

  assign data_sel = csr_addr == DATA_ADDR;
  assign stat_sel = csr_addr == STATUS_ADDR;
  assign empty    = count == '0;
  assign full     = count == CW'(DEPTH);
  assign pop      = csr_enable && data_sel && !empty;
  assign push     = rx_valid && (!full || pop);
  assign drop     = rx_valid && full && !pop;

  // I-variants (op[2]=1) take the zero-extended immediate.
  assign clr_bit  = csr_op[2] ? rs1_zimm[0] : rs1_data[0];
  assign clr      = csr_enable && stat_sel && clr_bit;

  // Only bit 0 of the operand matters for write-1-to-clear.
  assign unused_ok = ^{rs1_data[31:1], rs1_zimm[4:1]};

  // Next fill level and next sticky overflow; a drop beats a clear.
  always_comb begin
    count_n = count;
    ovf_n   = ovf;
    if (push && !pop) count_n = count + CW'(1);
    if (!push && pop) count_n = count - CW'(1);
    if (clr)  ovf_n = 1'b0;
    if (drop) ovf_n = 1'b1;
  end

  // Byte storage; stale contents are harmless since pointers reset.
  always_ff @(posedge clk_i) begin
    if (push) mem[wp] <= rx_data;
  end

  // Pointers, level and overflow flag with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
      count <= count_n;
      ovf   <= ovf_n;
    end
  end

`ifdef UART_RX_FIFO_IRQ_EN
  // Level interrupt tracks the post-edge fill level and overflow.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) irq_o <= 1'b0;
    else irq_o <= (count_n >= CW'(IRQ_LEVEL)) || ovf_n;
  end
`endif

  // CSR read mux; driven regardless of csr_enable.
  always_comb begin
    csr_data_out = '0;
    unique case (1'b1)
      data_sel: if (!empty) csr_data_out = {1'b1, 23'b0, mem[rp]};
      stat_sel: csr_data_out = {16'b0, 8'(count), 5'b0, full, empty, ovf};
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed vectors for uart_rx_fifo (DEPTH=16).
// irq_o checks are active when UART_RX_FIFO_IRQ_EN is defined.
module tb_uart_rx_fifo;
  import uart_rx_fifo_pkg::*;

  typedef struct {
    logic        rv;
    logic [7:0]  rd;
    logic        en;
    logic [11:0] addr;
    csr_op_t     op;
    logic [31:0] rs1;
    logic [4:0]  zimm;
    logic [31:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_ni = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        csr_enable = 1'b0;
  logic [11:0] csr_addr = '0;
  logic [4:0]  rs1_zimm = '0;
  logic [31:0] rs1_data = '0;
  csr_op_t     csr_op = CSRRS;
  logic [31:0] csr_data_out;
`ifdef UART_RX_FIFO_IRQ_EN
  logic        irq_o;
`endif

  int checks = 0;
  int failures = 0;

  uart_rx_fifo #(
    .DEPTH(16),
    .DATA_ADDR(12'h52),
    .STATUS_ADDR(12'h53),
    .IRQ_LEVEL(4)
  ) dut (
    .clk_i(clk),
    .reset_ni(reset_ni),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .csr_enable(csr_enable),
    .csr_addr(csr_addr),
    .rs1_zimm(rs1_zimm),
    .rs1_data(rs1_data),
    .csr_op(csr_op),
    .csr_data_out(csr_data_out)
`ifdef UART_RX_FIFO_IRQ_EN
    ,
    .irq_o(irq_o)
`endif
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic rv, logic [7:0] rd, logic en,
                              logic [11:0] a, csr_op_t op,
                              logic [31:0] rs1, logic [4:0] z,
                              logic [31:0] e);
    vec_t v;
    v.rv = rv; v.rd = rd; v.en = en; v.addr = a;
    v.op = op; v.rs1 = rs1; v.zimm = z; v.exp = e;
    return v;
  endfunction

  function automatic vec_t psh(logic [7:0] b);
    return mk(1'b1, b, 1'b0, 12'h0, CSRRS, 32'h0, 5'h0, 32'h0);
  endfunction

  function automatic vec_t rdv(logic [31:0] e);
    return mk(1'b0, 8'h0, 1'b1, 12'h52, CSRRS, 32'h0, 5'h0, e);
  endfunction

  function automatic vec_t stv(logic [31:0] e);
    return mk(1'b0, 8'h0, 1'b1, 12'h53, CSRRS, 32'h0, 5'h0, e);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  // Drive at negedge, compare combinational output before the posedge.
  task automatic step(input vec_t v, input string nm);
    @(negedge clk);
    rx_valid   = v.rv;
    rx_data    = v.rd;
    csr_enable = v.en;
    csr_addr   = v.addr;
    csr_op     = v.op;
    rs1_data   = v.rs1;
    rs1_zimm   = v.zimm;
    #1 chk(nm, csr_data_out, v.exp);
  endtask

  task automatic idle_in();
    rx_valid = 1'b0;
    csr_enable = 1'b0;
    csr_addr = '0;
    rs1_data = '0;
    rs1_zimm = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_in();
    reset_ni = 1'b0;
    @(negedge clk);
    reset_ni = 1'b1;
  endtask

  vec_t tbl [11];

  initial begin
    tbl[0]  = psh(8'hDE);
    tbl[1]  = psh(8'hAD);
    tbl[2]  = psh(8'hBE);
    tbl[3]  = psh(8'hEF);
    tbl[4]  = stv(32'h0000_0400);
    tbl[5]  = rdv(32'h8000_00DE);
    tbl[6]  = rdv(32'h8000_00AD);
    tbl[7]  = rdv(32'h8000_00BE);
    tbl[8]  = rdv(32'h8000_00EF);
    tbl[9]  = rdv(32'h0000_0000);
    tbl[10] = stv(32'h0000_0002);

    do_reset();
    step(stv(32'h2), "reset_status");
    step(rdv(32'h0), "reset_data");
    step(mk(1'b0, 8'h0, 1'b1, 12'h99, CSRRS, 32'h0, 5'h0, 32'h0),
         "other_addr");

    for (int i = 0; i < 11; i++) step(tbl[i], $sformatf("fill_drain%0d", i));

    for (int i = 0; i < 17; i++) step(psh(8'(i)), "ovf_push");
    step(stv(32'h1005), "ovf_status");
    step(mk(1'b1, 8'h99, 1'b1, 12'h53, CSRRW, 32'h1, 5'h0, 32'h1005),
         "ovf_clr_race");
    step(stv(32'h1005), "ovf_wins");
    for (int i = 0; i < 16; i++)
      step(rdv({24'h800000, 8'(i)}), "ovf_drain");
    step(stv(32'h3), "ovf_empty");
    step(mk(1'b0, 8'h0, 1'b1, 12'h53, CSRRWI, 32'h0, 5'h1, 32'h3),
         "ovf_clr");
    step(stv(32'h2), "ovf_cleared");

    for (int i = 0; i < 16; i++) step(psh(8'(8'h20 + i)), "full_push");
    step(stv(32'h1004), "full_status");
    step(mk(1'b1, 8'h55, 1'b1, 12'h52, CSRRS, 32'h0, 5'h0, 32'h8000_0020),
         "full_pushpop");
    step(stv(32'h1004), "full_after");
    for (int i = 1; i < 16; i++)
      step(rdv({24'h800000, 8'(8'h20 + i)}), "full_drain");
    step(rdv(32'h8000_0055), "full_last");
    step(rdv(32'h0), "full_empty");

    step(mk(1'b1, 8'h77, 1'b1, 12'h52, CSRRS, 32'h0, 5'h0, 32'h0),
         "empty_pushpop");
    step(stv(32'h0100), "empty_count1");
    step(rdv(32'h8000_0077), "empty_data");
    step(stv(32'h2), "empty_status");

    for (int i = 0; i < 40; i++) begin
      step(psh(8'(i * 7 + 3)), "wrap_push");
      step(rdv({24'h800000, 8'(i * 7 + 3)}), "wrap_read");
    end
    step(stv(32'h2), "wrap_status");

    for (int i = 0; i < 5; i++) step(psh(8'(8'hA0 + i)), "mid_push");
    @(negedge clk);
    reset_ni = 1'b0;
    rx_valid = 1'b1;
    rx_data = 8'hAA;
    csr_enable = 1'b1;
    csr_addr = 12'h52;
    @(negedge clk);
    reset_ni = 1'b1;
    idle_in();
    step(stv(32'h2), "mid_reset_status");
    step(rdv(32'h0), "mid_reset_data");

`ifdef UART_RX_FIFO_IRQ_EN
    do_reset();
    chk("irq_reset", {31'b0, irq_o}, 32'h0);
    for (int i = 0; i < 3; i++) step(psh(8'(i + 1)), "irq_push");
    step(stv(32'h0300), "irq_status3");
    chk("irq_at3", {31'b0, irq_o}, 32'h0);
    step(psh(8'h4), "irq_push4");
    step(stv(32'h0400), "irq_status4");
    chk("irq_at4", {31'b0, irq_o}, 32'h1);
    step(rdv(32'h8000_0001), "irq_pop");
    step(stv(32'h0300), "irq_status_pop");
    chk("irq_after_pop", {31'b0, irq_o}, 32'h0);
`endif

    @(negedge clk);
    idle_in();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
